// File: rtl/mul_issue.sv
// Issue stage for RV32 M-extension multiplies: accepts a decoded request, drives an
// external multiplier, and returns a tagged response, short-circuiting zero operands.
module mul_issue #(
  parameter bit          SINGLE_CYCLE = 1'b0,
  localparam int unsigned XLEN        = 32,
  localparam int unsigned TAG_W       = 5,
  localparam int unsigned F3_W        = 3,
  localparam int unsigned SMODE_W     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [F3_W-1:0]    funct3_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    rs2_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               enable_o,
  output logic [XLEN-1:0]    first_operand_o,
  output logic [XLEN-1:0]    second_operand_o,
  output logic [SMODE_W-1:0] signed_mode_o,
  output logic               mul_low_o,
  output logic               single_cycle_o,
  input  logic               hold_i,
  input  logic [XLEN-1:0]    result_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [XLEN-1:0]    rsp_data_o,
  output logic [TAG_W-1:0]   rsp_tag_o,
  output logic               rsp_err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BUSY = 3'b010,
    S_RESP = 3'b100
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]    op1_q, op1_d;
  logic [XLEN-1:0]    op2_q, op2_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [SMODE_W-1:0] smode_q, smode_d;
  logic               low_q, low_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic               err_q, err_d;

  logic accept_c;
  logic illegal_c;
  logic zero_c;
  logic shortcut_c;

  assign accept_c   = req_valid_i & req_ready_o;
  assign illegal_c  = funct3_i[2];
  assign zero_c     = (rs1_i == '0) || (rs2_i == '0);
  // Illegal ops and zero operands both skip the multiplier entirely
  assign shortcut_c = illegal_c | zero_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = shortcut_c ? S_RESP : S_BUSY;
      end
      S_BUSY: begin
        if (!hold_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (accept_c)         state_d = shortcut_c ? S_RESP : S_BUSY;
        else if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    enable_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: req_ready_o = 1'b1;
      S_BUSY: enable_o    = 1'b1;
      S_RESP: begin
        rsp_valid_o = 1'b1;
        req_ready_o = rsp_ready_i;
      end
      default: ;
    endcase
  end

  // Request capture and result latch; nothing changes while BUSY except the result
  always_comb begin
    op1_d   = op1_q;
    op2_d   = op2_q;
    tag_d   = tag_q;
    smode_d = smode_q;
    low_d   = low_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept_c) begin
      op1_d  = rs1_i;
      op2_d  = rs2_i;
      tag_d  = tag_i;
      err_d  = illegal_c;
      data_d = '0;
      case (funct3_i)
        3'b000:  {smode_d, low_d} = {2'b00, 1'b1};
        3'b001:  {smode_d, low_d} = {2'b11, 1'b0};
        3'b010:  {smode_d, low_d} = {2'b01, 1'b0};
        3'b011:  {smode_d, low_d} = {2'b00, 1'b0};
        default: {smode_d, low_d} = {2'b00, 1'b0};
      endcase
    end else if ((state_q == S_BUSY) && !hold_i) begin
      data_d = result_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op1_q   <= '0;
      op2_q   <= '0;
      tag_q   <= '0;
      smode_q <= '0;
      low_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      tag_q   <= tag_d;
      smode_q <= smode_d;
      low_q   <= low_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign first_operand_o  = op1_q;
  assign second_operand_o = op2_q;
  assign signed_mode_o    = smode_q;
  assign mul_low_o        = low_q;
  assign rsp_data_o       = data_q;
  assign rsp_tag_o        = tag_q;
  assign rsp_err_o        = err_q;
  assign single_cycle_o   = SINGLE_CYCLE;

endmodule

// File: tb/tb_mul_issue.sv
// Scoreboard bench for mul_issue: a behavioural multiplier answers the DUT, and an
// arithmetic reference model predicts every tagged response.
module tb_mul_issue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  tag_i = '0;
  logic        enable_o;
  logic [31:0] first_operand_o, second_operand_o;
  logic [1:0]  signed_mode_o;
  logic        mul_low_o;
  logic        single_cycle_o;
  logic        hold_i = 1'b0;
  logic [31:0] result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_tag_o;
  logic        rsp_err_o;

  mul_issue #(.SINGLE_CYCLE(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i),
    .enable_o(enable_o), .first_operand_o(first_operand_o),
    .second_operand_o(second_operand_o), .signed_mode_o(signed_mode_o),
    .mul_low_o(mul_low_o), .single_cycle_o(single_cycle_o),
    .hold_i(hold_i), .result_i(result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier driven purely by what the DUT presents
  logic [63:0] m_a, m_b, m_p;
  assign m_a      = signed_mode_o[0] ? {{32{first_operand_o[31]}}, first_operand_o}
                                     : {32'h0, first_operand_o};
  assign m_b      = signed_mode_o[1] ? {{32{second_operand_o[31]}}, second_operand_o}
                                     : {32'h0, second_operand_o};
  assign m_p      = m_a * m_b;
  assign result_i = !enable_o ? 32'hDEADBEEF : (mul_low_o ? m_p[31:0] : m_p[63:32]);

  typedef struct {
    logic [31:0] rs1, rs2, data;
    logic [4:0]  tag;
    logic [2:0]  f3;
    logic        err, shortcut;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0, fails = 0;
  int cyc = 0, en_cnt = 0, hold_cnt = 0, nsent = 0, npop = 0, hold_left = 0;
  bit rsp_seen = 0, hold_rand = 0, rnd_on = 0;
  logic [31:0] last_data;
  logic [4:0]  last_tag;
  logic        last_err;
  int          last_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics in plain 64-bit arithmetic
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, b,
                                 input logic [4:0] tag, input int c);
    exp_t e;
    longint sa, sb, p;
    e.rs1 = a; e.rs2 = b; e.tag = tag; e.f3 = f3; e.acc_cyc = c;
    e.err = f3[2];
    e.shortcut = f3[2] || (a == 0) || (b == 0);
    e.data = '0;
    if (!e.shortcut) begin
      sa = (f3[1:0] == 2'd1 || f3[1:0] == 2'd2) ? longint'($signed(a)) : longint'({32'h0, a});
      sb = (f3[1:0] == 2'd1) ? longint'($signed(b)) : longint'({32'h0, b});
      p  = sa * sb;
      e.data = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
    end
    return e;
  endfunction

  function automatic logic [2:0] exp_mode(input logic [2:0] f3);
    case (f3)
      3'b000:  return 3'b001;
      3'b001:  return 3'b110;
      3'b010:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier busy: forced hold count first, otherwise random or zero
  always @(posedge clk) begin
    #1;
    if (enable_o && hold_left > 0) begin
      hold_i = 1'b1;
      hold_left--;
    end else if (hold_rand) begin
      hold_i = ($urandom_range(0, 2) == 0);
    end else begin
      hold_i = 1'b0;
    end
  end

  // Monitor: checks BUSY-phase drive and every RESP cycle against the queue head
  always @(negedge clk) begin
    if (reset_n) begin
      if (enable_o) begin
        en_cnt++;
        if (hold_i) hold_cnt++;
        if (q.size() == 0) chk("busy_without_request", 64'(enable_o), 64'd0);
        else begin
          chk("first_operand", 64'(first_operand_o), 64'(q[0].rs1));
          chk("second_operand", 64'(second_operand_o), 64'(q[0].rs2));
          chk("decode_mode_low", 64'({signed_mode_o, mul_low_o}), 64'(exp_mode(q[0].f3)));
        end
      end
      if (rsp_valid_o) begin
        if (q.size() == 0) chk("spurious_rsp_valid", 64'(rsp_valid_o), 64'd0);
        else begin
          if (!rsp_seen) begin
            rsp_seen = 1;
            chk("latency", 64'(cyc - q[0].acc_cyc), q[0].shortcut ? 64'd1 : 64'(2 + hold_cnt));
            chk("enable_cycles", 64'(en_cnt), q[0].shortcut ? 64'd0 : 64'(hold_cnt + 1));
          end
          chk("rsp_data", 64'(rsp_data_o), 64'(q[0].data));
          chk("rsp_tag", 64'(rsp_tag_o), 64'(q[0].tag));
          chk("rsp_err", 64'(rsp_err_o), 64'(q[0].err));
          if (rsp_ready_i) begin
            last_data = rsp_data_o; last_tag = rsp_tag_o; last_err = rsp_err_o;
            last_en = en_cnt;
            void'(q.pop_front());
            npop++; rsp_seen = 0; en_cnt = 0; hold_cnt = 0;
          end
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [2:0] f3, input logic [31:0] a, b, input logic [4:0] tag,
                      output int waited);
    bit ok = 0;
    req_valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; tag_i = tag;
    waited = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        q.push_back(model(f3, a, b, tag, cyc));
        nsent++;
        ok = 1;
      end else waited++;
    end
    if (!ok) chk("accept_timeout", 64'(req_ready_o), 64'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    funct3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom; tag_i = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid_o) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 1ms", $time);
    $fatal(1);
  end

  initial begin
    int w, n;
    logic [2:0] f3;
    logic [31:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_enable", 64'(enable_o), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err_o), 64'd0);
    chk("reset_regs", {rsp_data_o, 27'(rsp_tag_o), signed_mode_o, 3'(mul_low_o)}, 64'd0);
    chk("reset_operands", {first_operand_o, second_operand_o}, 64'd0);
    chk("reset_ready", 64'(req_ready_o), 64'd1);
    chk("single_cycle_param", 64'(single_cycle_o), 64'd0);

    // First accept on the first edge after release; MUL 7*6 with three hold cycles
    reset_n = 1'b1;
    hold_left = 3;
    send(3'b000, 32'd7, 32'd6, 5'd5, w);
    chk("first_accept_wait", 64'(w), 64'd0);
    drain();
    chk("mul_7x6_data", 64'(last_data), 64'd42);
    chk("mul_7x6_tag", 64'(last_tag), 64'd5);
    chk("mul_7x6_enable_cycles", 64'(last_en), 64'd4);

    send(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, w); drain();
    chk("mulh_m1_m1", 64'(last_data), 64'h0);
    send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, w); drain();
    chk("mulhu_max", 64'(last_data), 64'hFFFFFFFE);

    send(3'b101, 32'd3, 32'd4, 5'd9, w); drain();
    chk("illegal_err", 64'(last_err), 64'd1);
    chk("illegal_data", 64'(last_data), 64'd0);
    chk("illegal_enable", 64'(last_en), 64'd0);
    send(3'b000, 32'd0, 32'd123, 5'd10, w); drain();
    chk("zero_err", 64'(last_err), 64'd0);
    chk("zero_enable", 64'(last_en), 64'd0);
    send(3'b001, 32'h80000000, 32'd0, 5'd11, w); drain();
    chk("mulh_zero_enable", 64'(last_en), 64'd0);

    // Stalled response with a new request waiting
    rsp_ready_i = 1'b0;
    send(3'b000, 32'd0, 32'd9, 5'd2, w);
    n = 0;
    while (!rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    chk("stall_rsp_reached", 64'(rsp_valid_o), 64'd1);
    req_valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd5; tag_i = 5'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready_low", 64'(req_ready_o), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    send(3'b000, 32'd3, 32'd5, 5'd3, w);
    chk("stall_release_same_cycle", 64'(w), 64'd0);
    drain();
    chk("stall_next_data", 64'(last_data), 64'd15);
    chk("stall_next_tag", 64'(last_tag), 64'd3);

    // Randomized traffic with random hold and backpressure
    nsent = 0; npop = 0;
    hold_rand = 1; rnd_on = 1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          f3 = ($urandom_range(0, 4) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
          a  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
          b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
          if ($urandom_range(0, 3) == 0) a = 32'(int'($urandom_range(0, 20)) - 10);
          send(f3, a, b, 5'($urandom), w);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    hold_rand = 0;
    rsp_ready_i = 1'b1;
    drain();
    chk("random_all_responses", 64'(npop), 64'(nsent));

    // Reset in the middle of a held multiply
    hold_left = 50;
    send(3'b000, 32'd3, 32'd5, 5'd7, w);
    n = 0;
    while (!enable_o && n < 20) begin @(posedge clk); #1; n++; end
    chk("reset_test_busy", 64'(enable_o), 64'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_enable", 64'(enable_o), 64'd0);
    chk("async_reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("async_reset_operand", 64'(first_operand_o), 64'd0);
    q.delete();
    en_cnt = 0; hold_cnt = 0; rsp_seen = 0; hold_left = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("post_reset_no_rsp", 64'(rsp_valid_o), 64'd0);
    send(3'b000, 32'd3, 32'd5, 5'd7, w);
    drain();
    chk("post_reset_data", 64'(last_data), 64'd15);
    chk("post_reset_tag", 64'(last_tag), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 SHALL have parameter SINGLE_CYCLE, default 0, value driven on single_cycle_o.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid_i  in  1  decode offers an M-extension request.
REQ-005 req_ready_o  out  1  block accepts the request this cycle.
REQ-006 funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx illegal here.
REQ-007 rs1_i, rs2_i  in  32 each  source operands.
REQ-008 tag_i  in  5  destination register index.
REQ-009 enable_o  out  1  multiplier start/hold-request.
REQ-010 first_operand_o, second_operand_o  out  32 each  registered rs1/rs2.
REQ-011 signed_mode_o  out  2  bit0 first operand signed, bit1 second operand signed.
REQ-012 mul_low_o  out  1  1 selects result bits [31:0], 0 selects [63:32].
REQ-013 single_cycle_o  out  1  equals SINGLE_CYCLE.
REQ-014 hold_i  in  1  multiplier busy.
REQ-015 result_i  in  32  multiplier result.
REQ-016 rsp_valid_o  out  1  response available.
REQ-017 rsp_ready_i  in  1  writeback consumes the response.
REQ-018 rsp_data_o  out  32  result.
REQ-019 rsp_tag_o  out  5  tag of the request.
REQ-020 rsp_err_o  out  1  request had illegal funct3.

Function
REQ-021 SHALL implement one-hot states IDLE, BUSY, RESP.
REQ-022 req_ready_o SHALL be 1 in IDLE, 1 in RESP when rsp_ready_i=1, 0 otherwise; accept = req_valid_i & req_ready_o.
REQ-023 On accept, SHALL register operands, tag, and decode: MUL {00,1}, MULH {11,0}, MULHSU {01,0}, MULHU {00,0} as {signed_mode_o, mul_low_o}.
REQ-024 Accept with funct3[2]=1: next state RESP, rsp_data_o=0, rsp_err_o=1, multiplier not enabled.
REQ-025 Accept with rs1_i=0 or rs2_i=0 (legal funct3): next state RESP, rsp_data_o=0, rsp_err_o=0, multiplier not enabled.
REQ-026 Any other accept: next state BUSY.
REQ-027 In BUSY, enable_o SHALL be 1, with operands, signed_mode_o, and mul_low_o held stable; enable_o SHALL be 0 in IDLE and RESP.
REQ-028 In BUSY with hold_i=0, SHALL capture result_i into rsp_data_o and move to RESP next cycle; hold_i=1 keeps BUSY.
REQ-029 If hold_i=0 in the first BUSY cycle (single-cycle multiplier), latency from accept to rsp_valid_o SHALL be 2 cycles; otherwise it is 2 plus the number of hold_i=1 cycles.
REQ-030 In RESP, rsp_valid_o=1; rsp_data_o, rsp_tag_o, and rsp_err_o SHALL be stable until rsp_ready_i=1.
REQ-031 RESP with rsp_ready_i=1 and no accept: next state IDLE; with accept: per REQ-024..026 (back-to-back, no bubble).
REQ-032 rsp_valid_o SHALL be 0 in IDLE and BUSY.
REQ-033 req_valid_i while not ready SHALL be ignored; no request is lost or duplicated.
REQ-034 Zero shortcut (REQ-025) SHALL take priority over multiplier issue for all legal funct3 including MULH variants.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE and set enable_o, rsp_valid_o, and rsp_err_o to 0; operand, data, tag, signed_mode_o, and mul_low_o registers to 0.
REQ-036 Reset during BUSY or RESP SHALL abandon the operation; after release, no response for it is produced.
REQ-037 First accept SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-038 MUL rs1=7, rs2=6, hold_i=1 for 3 cycles -> signed_mode_o=00, mul_low_o=1, enable_o high 4 cycles, rsp_data_o=42 with tag echoed.
REQ-039 MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> signed_mode_o=11, mul_low_o=0, rsp_data_o=result_i=0x00000000; MULHU same operands -> signed_mode_o=00, expect 0xFFFFFFFE.
REQ-040 funct3=101, and separately MUL rs1=0 -> RESP after 1 cycle, enable_o never high, data 0, rsp_err_o 1 and 0 respectively.
REQ-041 rsp_ready_i=0 for 5 cycles while new req_valid_i high -> req_ready_o=0, outputs stable; on rsp_ready_i=1 the next request is accepted the same cycle.
REQ-042 reset_n low for 1 cycle mid-BUSY -> enable_o drops asynchronously, no rsp_valid_o afterwards, next request completes normally.
